mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store unit between the CPU datapath and the word-addressed data memory (8-bit word index,
//  32-bit data, combinational read, posedge write). Accepts byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw
//  requests over a valid/ready handshake. Sub-word stores use read-modify-write; loads are
//  extracted and sign/zero-extended. Misaligned, out-of-window or illegal-size requests complete
//  with an error flag and no memory access.
// PARAMETERS
//  BASE_ADDR   32'h10010000  byte address mapped to memory word 0
//  MEM_ADDR_W  8             memory word-index width; window = 4*2^MEM_ADDR_W bytes
// PORTS
//  clk             in   1   clock, all state updates on posedge
//  rst_n           in   1   asynchronous reset, active-low
//  req_valid       in   1   request present
//  req_ready       out  1   unit can accept; high only in IDLE
//  req_write       in   1   1 = store, 0 = load
//  req_size        in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned    in   1   loads: 1 = zero-extend, 0 = sign-extend
//  req_addr        in   32  byte address
//  req_wdata       in   32  store data; byte/half taken from low bits
//  resp_valid      out  1   response held until accepted
//  resp_ready      in   1   consumer accepts response
//  resp_rdata      out  32  load result (0 for stores and errors)
//  resp_error      out  1   request rejected (misaligned/out of window/size 11)
//  mem_addr        out  MEM_ADDR_W  word index to data memory
//  mem_write_data  out  32  word to data memory
//  mem_write       out  1   memory write enable
//  mem_read        out  1   memory read enable
//  mem_read_data   in   32  combinational read word from memory
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_error=0; mem_write=0,
//   mem_read=0, mem_addr=0, mem_write_data=0. mem_* are decoded from state, so reset mid-access
//   drops mem_write immediately; an aborted RMW leaves memory untouched; pending response lost.
//  Address: off = req_addr - BASE_ADDR (mod 2^32); in window iff off < 4*2^MEM_ADDR_W
//   (addresses below BASE wrap large -> error). Word index = off[MEM_ADDR_W+1:2]; lane = off[1:0].
//  Alignment: half needs off[0]=0, word needs off[1:0]=0. Little-endian: lane 0 = bits[7:0];
//   half at lane 2 = bits[31:16].
//  Handshake: request accepted on posedge with req_valid & req_ready; all fields captured then.
//   Response retires on posedge with resp_valid & resp_ready; next request accepted no earlier
//   than the following cycle (req_ready rises in IDLE).
//  FSM:
//   IDLE -> ERR_RESP  if illegal size, misaligned or out of window
//        -> READ      load;  -> RMW_RD  sb/sh;  -> WRITE  sw
//   READ:    mem_read=1; register extracted/extended lane data into resp_rdata -> RESP
//   RMW_RD:  mem_read=1; register mem_read_data with store lane(s) replaced -> WRITE
//   WRITE:   mem_write=1, mem_write_data = merged word (sb/sh) or req_wdata (sw) -> RESP
//   RESP / ERR_RESP: resp_valid=1 (resp_error=1 in ERR_RESP); hold outputs until resp_ready -> IDLE
//  mem_addr = captured word index in READ/RMW_RD/WRITE, else 0; mem_read/mem_write never both high.
//  Latency, accept edge T: error resp_valid at T+1; load and sw at T+2; sb/sh at T+3.
//  Extension: byte sign bit = bit7 of lane, half sign bit = bit15 of half; word loads ignore req_unsigned.
//  resp_ready held low: FSM stalls in RESP, no further memory traffic; resp_rdata/resp_error stable.
// TESTING
//  1 Reset: rst_n low mid-WRITE of sb -> mem_write drops same cycle, word unchanged, IDLE, req_ready=1.
//  2 sw 0xDEADBEEF @0x10010004, then lw same -> word[1]=DEADBEEF, rdata=DEADBEEF, resp at T+2 each.
//  3 Word[2]=0x11223344; sb 0xAA @0x1001000A -> word[2]=0x11AA3344, resp at T+3;
//    then lb -> 0xFFFFFFAA, lbu -> 0x000000AA.
//  4 Word[3]=0x8001_7FFF; lh @0x1001000E -> 0xFFFF8001; lhu @0x1001000C -> 0x00007FFF.
//  5 Errors: lw @0x10010002, sh @0x10010001, lw @0x1000FFFC, lw @0x10010400, size 11
//    -> resp_error=1 at T+1, rdata=0, no mem_read/mem_write.
//  6 Backpressure: resp_ready low 5 cycles after lw -> resp held stable, req_ready=0, no memory
//    strobes; back-to-back requests with resp_ready=1 retire in order.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU datapath and a word-addressed data memory.
// Byte-addressed sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
module mem_access_unit #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
  parameter int          MEM_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_write_data,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [31:0]           mem_read_data
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_RMW_RD   = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RESP     = 3'd4,
    ST_ERR_RESP = 3'd5
  } state_t;

  localparam logic [32:0] WIN_BYTES = 33'd4 << MEM_ADDR_W;

  state_t                 state_q, state_d;
  logic [MEM_ADDR_W-1:0]  widx_q;
  logic [1:0]             lane_q;
  logic [1:0]             size_q;
  logic                   uns_q;
  logic [31:0]            wword_q;
  logic [31:0]            rdata_q;

  logic [31:0]            off_s;
  logic                   bad_s;

  // Replace the addressed byte/half lane of old_w with the low bits of wd.
  function automatic logic [31:0] merge_store(input logic [31:0] old_w, input logic [31:0] wd,
                                              input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] r;
    r = old_w;
    case (size)
      2'b00:   r[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01: begin
        if (lane[1]) r[31:16] = wd[15:0];
        else         r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  // Pick the addressed lane out of a memory word and sign/zero-extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Request decode: addresses below BASE wrap to a large offset and fall outside the window.
  always_comb begin
    off_s = req_addr - BASE_ADDR;
    bad_s = 1'b0;
    if (req_size == 2'b11) begin
      bad_s = 1'b1;
    end else if ({1'b0, off_s} >= WIN_BYTES) begin
      bad_s = 1'b1;
    end else if ((req_size == 2'b01) && off_s[0]) begin
      bad_s = 1'b1;
    end else if ((req_size == 2'b10) && (off_s[1:0] != 2'b00)) begin
      bad_s = 1'b1;
    end else begin
      bad_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!req_valid)                state_d = ST_IDLE;
        else if (bad_s)                state_d = ST_ERR_RESP;
        else if (!req_write)           state_d = ST_READ;
        else if (req_size == 2'b10)    state_d = ST_WRITE;
        else                           state_d = ST_RMW_RD;
      end
      ST_READ:   state_d = ST_RESP;
      ST_RMW_RD: state_d = ST_WRITE;
      ST_WRITE:  state_d = ST_RESP;
      ST_RESP, ST_ERR_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
        else            state_d = state_q;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request capture, load result and merged store word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx_q  <= '0;
      lane_q  <= 2'b00;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wword_q <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            widx_q  <= off_s[MEM_ADDR_W+1:2];
            lane_q  <= off_s[1:0];
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wword_q <= req_wdata;
            rdata_q <= 32'h0000_0000;
          end
        end
        ST_READ:   rdata_q <= load_extract(mem_read_data, lane_q, size_q, uns_q);
        ST_RMW_RD: wword_q <= merge_store(mem_read_data, wword_q, lane_q, size_q);
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from the state register so a reset drops memory strobes immediately.
  always_comb begin
    req_ready      = (state_q == ST_IDLE);
    resp_valid     = (state_q == ST_RESP) || (state_q == ST_ERR_RESP);
    resp_error     = (state_q == ST_ERR_RESP);
    resp_rdata     = rdata_q;
    mem_read       = (state_q == ST_READ) || (state_q == ST_RMW_RD);
    mem_write      = (state_q == ST_WRITE);
    mem_addr       = '0;
    mem_write_data = 32'h0000_0000;
    if (mem_read || mem_write) mem_addr = widx_q;
    else                       mem_addr = '0;
    if (mem_write) mem_write_data = wword_q;
    else           mem_write_data = 32'h0000_0000;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory and an in-order
// scoreboard of expected responses (data, error, latency, memory strobe counts).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_rdata;
  logic [7:0]  mem_addr;
  logic [31:0] mem_write_data, mem_read_data;
  logic        mem_write, mem_read;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_error(resp_error),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_write(mem_write),
    .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  logic [31:0] mem [0:255];
  assign mem_read_data = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_write_data;
  end

  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;
  always @(posedge clk) begin
    if (mem_read)              rd_cnt   <= rd_cnt + 1;
    if (mem_write)             wr_cnt   <= wr_cnt + 1;
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   rd0, wr0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // lat = negedges after the accept negedge until resp_valid is seen.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input int nrd, input int nwr);
    int w;
    sb_q.push_back('{exp_rd, exp_err, lat, nrd, nwr});
    @(negedge clk);
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", 32'(req_ready), 32'd1);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int hold);
    exp_t        e;
    int          lat;
    logic [31:0] first;
    @(negedge clk);
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    e = sb_q.pop_front();
    chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
    first = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
      chk({tag, "_hold_data"}, resp_rdata, first);
    end
    chk({tag, "_rdata"}, resp_rdata, e.rdata);
    chk({tag, "_err"}, 32'(resp_error), 32'(e.err));
    chk({tag, "_nrd"}, 32'(rd_cnt - rd0), 32'(e.nrd));
    chk({tag, "_nwr"}, 32'(wr_cnt - wr0), 32'(e.nwr));
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, {30'd0, resp_valid, req_ready}, 32'd1);
  endtask

  task automatic xact(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input int lat, input int nrd, input int nwr);
    issue(wr, sz, uns, addr, wd, exp_rd, exp_err, lat, nrd, nwr);
    collect(tag, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    #12;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp", {29'd0, resp_valid, resp_error, 1'b0}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_mem", {22'd0, mem_addr, mem_read, mem_write}, 32'd0);
    chk("rst_wdata", mem_write_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during the WRITE phase of an sb leaves memory untouched.
    xact("sw4", 1'b1, 2'b10, 1'b0, 32'h1001_0010, 32'h5566_7788, 32'h0, 1'b0, 1, 0, 1);
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b00; req_addr = 32'h1001_0011; req_wdata = 32'h0000_0099;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_rmw_rd", 32'(mem_read), 32'd1);
    @(negedge clk);
    chk("abort_write", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_wr_drop", 32'(mem_write), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_word", mem[4], 32'h5566_7788);
    xact("lw4", 1'b0, 2'b10, 1'b0, 32'h1001_0010, 32'h0, 32'h5566_7788, 1'b0, 1, 1, 0);

    xact("sw1", 1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0, 1'b0, 1, 0, 1);
    chk("word1", mem[1], 32'hDEAD_BEEF);
    xact("lw1", 1'b0, 2'b10, 1'b1, 32'h1001_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 1, 1, 0);

    xact("sw2", 1'b1, 2'b10, 1'b0, 32'h1001_0008, 32'h1122_3344, 32'h0, 1'b0, 1, 0, 1);
    xact("sb2", 1'b1, 2'b00, 1'b0, 32'h1001_000A, 32'h1234_56AA, 32'h0, 1'b0, 2, 1, 1);
    chk("word2", mem[2], 32'h11AA_3344);
    xact("lb2", 1'b0, 2'b00, 1'b0, 32'h1001_000A, 32'h0, 32'hFFFF_FFAA, 1'b0, 1, 1, 0);
    xact("lbu2", 1'b0, 2'b00, 1'b1, 32'h1001_000A, 32'h0, 32'h0000_00AA, 1'b0, 1, 1, 0);

    xact("sw3", 1'b1, 2'b10, 1'b0, 32'h1001_000C, 32'h8001_7FFF, 32'h0, 1'b0, 1, 0, 1);
    xact("lh3", 1'b0, 2'b01, 1'b0, 32'h1001_000E, 32'h0, 32'hFFFF_8001, 1'b0, 1, 1, 0);
    xact("lhu3", 1'b0, 2'b01, 1'b1, 32'h1001_000C, 32'h0, 32'h0000_7FFF, 1'b0, 1, 1, 0);
    xact("lh3lo", 1'b0, 2'b01, 1'b0, 32'h1001_000C, 32'h0, 32'h0000_7FFF, 1'b0, 1, 1, 0);
    xact("sh3", 1'b1, 2'b01, 1'b0, 32'h1001_000E, 32'h5555_BEEF, 32'h0, 1'b0, 2, 1, 1);
    chk("word3", mem[3], 32'hBEEF_7FFF);

    xact("e_lw_mis", 1'b0, 2'b10, 1'b0, 32'h1001_0002, 32'h0, 32'h0, 1'b1, 0, 0, 0);
    xact("e_sh_mis", 1'b1, 2'b01, 1'b0, 32'h1001_0001, 32'hFFFF, 32'h0, 1'b1, 0, 0, 0);
    xact("e_below", 1'b0, 2'b10, 1'b0, 32'h1000_FFFC, 32'h0, 32'h0, 1'b1, 0, 0, 0);
    xact("e_above", 1'b0, 2'b10, 1'b0, 32'h1001_0400, 32'h0, 32'h0, 1'b1, 0, 0, 0);
    xact("e_size", 1'b0, 2'b11, 1'b0, 32'h1001_0000, 32'h0, 32'h0, 1'b1, 0, 0, 0);
    chk("word1_kept", mem[1], 32'hDEAD_BEEF);

    issue(1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 1, 1, 0);
    collect("bp_lw", 5);

    issue(1'b0, 2'b00, 1'b1, 32'h1001_000B, 32'h0, 32'h0000_0011, 1'b0, 1, 1, 0);
    collect("b2b_lbu", 0);
    issue(1'b0, 2'b01, 1'b0, 32'h1001_0008, 32'h0, 32'h0000_3344, 1'b0, 1, 1, 0);
    collect("b2b_lh", 0);
    issue(1'b1, 2'b10, 1'b0, 32'h1001_03FC, 32'hCAFE_F00D, 32'h0, 1'b0, 1, 0, 1);
    collect("b2b_swtop", 0);
    issue(1'b0, 2'b10, 1'b0, 32'h1001_03FC, 32'h0, 32'hCAFE_F00D, 1'b0, 1, 1, 0);
    collect("b2b_lwtop", 0);

    chk("rd_wr_exclusive", 32'(both_cnt), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
